mux_arb_n: RTL and testbench
============================

// Module: mux_arb_n
// PURPOSE
//  NUM_CH-input, DATA_W-wide registered multiplexer with per-channel valid/ready handshake.
//  Two modes: fixed select (channel chosen by i_sel) and round-robin arbitration across all valid channels.
//  Output is a single register stage with full throughput (one transfer per cycle under back-pressure-free flow).
//  Used wherever several producers share one downstream consumer in the combinational/datapath exercises.
// PARAMETERS
//  NUM_CH   4   number of input channels, >= 2
//  DATA_W   8   data width per channel
//  CH_W     $clog2(NUM_CH)   channel index width (derived, not overridden)
// PORTS
//  i_clk        in   1              clock, all logic on rising edge
//  i_rst        in   1              synchronous reset, active-high
//  i_mode       in   1              0 = fixed select, 1 = round-robin
//  i_sel        in   CH_W           selected channel in fixed mode, ignored in RR mode
//  i_in_valid   in   NUM_CH         per-channel valid, bit k = channel k
//  i_in_data    in   NUM_CH*DATA_W  packed data, channel k at [k*DATA_W +: DATA_W]
//  o_in_ready   out  NUM_CH         per-channel ready, at most one bit set
//  o_valid      out  1              output register holds data
//  o_data       out  DATA_W         registered data
//  o_ch         out  CH_W           channel index that produced o_data
//  i_out_ready  in   1              downstream accepts o_data this cycle
// BEHAVIOUR
//  - Reset (i_rst=1 at clock edge): o_valid=0, o_data=0, o_ch=0, rr pointer=NUM_CH-1 (channel 0 has top priority first).
//  - load_en = !o_valid | i_out_ready. Output register loads only when load_en=1 and a grant exists.
//  - Grant (combinational, one-hot or zero):
//    fixed: grant[i_sel] = i_in_valid[i_sel]; i_sel >= NUM_CH -> no grant.
//    RR: first valid channel searched from ptr+1 upward, wrapping NUM_CH-1 -> 0.
//  - o_in_ready = grant & {NUM_CH{load_en}}; a transfer on channel k = i_in_valid[k] & o_in_ready[k].
//  - On transfer: o_data <= channel data, o_ch <= k, o_valid <= 1; in RR mode ptr <= k.
//  - No transfer and i_out_ready=1: o_valid <= 0, o_data/o_ch hold last value.
//  - o_valid=1 and i_out_ready=0: o_data, o_ch, o_valid hold; every o_in_ready bit = 0.
//  - Latency: input transfer at edge N -> o_valid at N+1; back-to-back transfers every cycle when i_out_ready=1.
//  - ptr only changes on RR-mode transfers; fixed-mode transfers leave it untouched.
//  - Mode or i_sel change: takes effect on the next grant evaluation; never alters the held output.
//  - o_in_ready depends combinationally on i_in_valid, i_mode, i_sel, i_out_ready; o_valid/o_data are purely registered.
//  - Reset mid-transfer: pending output dropped (o_valid=0); the accepted word is lost, by design.
//  - All NUM_CH valid continuously in RR mode: grants rotate 0,1,..,NUM_CH-1,0 with no starvation.
// STRUCTURE
//  - mux_pkg: MODE_FIXED=1'b0, MODE_RR=1'b1 localparams; CH_W derivation helper.
//  - Sub-module rr_arbiter (NUM_CH): inputs req, ptr, en; outputs one-hot grant and encoded index.
//  - Top: mode select of grant source, output register, ptr register, ready generation.
// TESTING
//  1 Reset: i_rst=1 two cycles, all valid=1 -> o_valid=0, o_data=0, o_ch=0, o_in_ready=0 during reset.
//  2 Fixed mode, i_sel=2, valid=4'b1111, data ch2=8'hA5, i_out_ready=1 -> o_in_ready=4'b0100, next cycle o_data=A5, o_ch=2.
//  3 RR mode, valid=4'b1111 held 8 cycles, i_out_ready=1 -> o_ch sequence 0,1,2,3,0,1,2,3.
//  4 RR mode, valid=4'b1010 -> o_ch alternates 1,3,1,3; channels 0 and 2 never get ready.
//  5 Back-pressure: o_valid=1, i_out_ready=0 for 3 cycles -> o_data stable, o_in_ready=0; release -> next word next cycle.
//  6 Fixed mode, i_sel=3 with NUM_CH=3 -> no grant, o_valid stays 0; reset asserted with o_valid=1 -> o_valid=0 next edge.

Source files
------------

// File: rtl/mux_pkg.sv
// +--------------------------------------------------------------------+
// | mux_pkg : shared constants and helpers for mux_arb_n               |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // A 2-channel mux still needs a 1-bit index, so never return 0.
  function automatic int ch_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +--------------------------------------------------------------------+
// | rr_arbiter : round-robin grant, search starts just above ptr       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   idx
);

  int   cand;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    // Last-granted channel is visited last, which gives the rotation.
    for (int off = 1; off <= NUM_CH; off++) begin
      cand = 32'(ptr) + off;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      if (en && !found && req[cand[CH_W-1:0]]) begin
        found                  = 1'b1;
        grant[cand[CH_W-1:0]]  = 1'b1;
        idx                    = cand[CH_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_arb_n.sv
// +--------------------------------------------------------------------+
// | mux_arb_n : registered N:1 mux, fixed-select or round-robin mode   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module mux_arb_n
  import mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 8,
  localparam int CH_W   = ch_width(NUM_CH)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_mode,
  input  logic [CH_W-1:0]          i_sel,
  input  logic [NUM_CH-1:0]        i_in_valid,
  input  logic [NUM_CH*DATA_W-1:0] i_in_data,
  output logic [NUM_CH-1:0]        o_in_ready,
  output logic                     o_valid,
  output logic [DATA_W-1:0]        o_data,
  output logic [CH_W-1:0]          o_ch,
  input  logic                     i_out_ready
);

  localparam logic [CH_W:0]   SEL_LIMIT = (CH_W+1)'(NUM_CH);
  localparam logic [CH_W-1:0] PTR_RST   = CH_W'(NUM_CH - 1);

  logic [NUM_CH-1:0] rr_grant, fix_grant, grant;
  logic [CH_W-1:0]   rr_idx, ch_sel;
  logic [DATA_W-1:0] data_sel;
  logic              load_en, xfer;

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic [CH_W-1:0]   ch_d, ch_q, ptr_d, ptr_q;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .req   (i_in_valid),
    .ptr   (ptr_q),
    .en    (i_mode == MODE_RR),
    .grant (rr_grant),
    .idx   (rr_idx)
  );

  always_comb begin
    fix_grant = '0;
    if (i_mode == MODE_FIXED && {1'b0, i_sel} < SEL_LIMIT)
      fix_grant[i_sel] = i_in_valid[i_sel];
    grant  = (i_mode == MODE_RR) ? rr_grant : fix_grant;
    ch_sel = (i_mode == MODE_RR) ? rr_idx : i_sel;

    data_sel = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (grant[k]) data_sel = i_in_data[k*DATA_W +: DATA_W];

    // Ready is held low during reset so nothing is offered to a register being cleared.
    load_en    = !valid_q || i_out_ready;
    xfer       = load_en && (|grant) && !i_rst;
    o_in_ready = grant & {NUM_CH{load_en && !i_rst}};

    valid_d = valid_q;
    data_d  = data_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      valid_d = 1'b1;
      data_d  = data_sel;
      ch_d    = ch_sel;
      if (i_mode == MODE_RR) ptr_d = ch_sel;
    end else if (i_out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= PTR_RST;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_ch    = ch_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_arb_n.sv
// +--------------------------------------------------------------------+
// | tb_mux_arb_n : directed + random checks against a reference model  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_mux_arb_n;

  logic        clk;
  logic        rst, mode, out_ready;
  logic [1:0]  sel;
  logic [3:0]  in_valid, in_ready;
  logic [31:0] in_data;
  logic        o_valid;
  logic [7:0]  o_data;
  logic [1:0]  o_ch;

  logic        rst3;
  logic [1:0]  sel3;
  logic [2:0]  valid3, ready3;
  logic [23:0] data3;
  logic        ov3;
  logic [7:0]  od3;
  logic [1:0]  oc3;

  int total = 0;
  int bad   = 0;

  int m_valid, m_data, m_ch, m_ptr;

  mux_arb_n #(.NUM_CH(4), .DATA_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_sel(sel),
    .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready),
    .o_valid(o_valid), .o_data(o_data), .o_ch(o_ch), .i_out_ready(out_ready)
  );

  mux_arb_n #(.NUM_CH(3), .DATA_W(8)) dut3 (
    .i_clk(clk), .i_rst(rst3), .i_mode(1'b0), .i_sel(sel3),
    .i_in_valid(valid3), .i_in_data(data3), .o_in_ready(ready3),
    .o_valid(ov3), .o_data(od3), .o_ch(oc3), .i_out_ready(1'b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Winning channel for the current inputs, -1 if none.
  function automatic int ref_grant();
    int c;
    if (mode == 1'b0) return in_valid[sel] ? int'(sel) : -1;
    for (int k = 1; k <= 4; k++) begin
      c = (m_ptr + k) % 4;
      if (in_valid[c[1:0]]) return c;
    end
    return -1;
  endfunction

  task automatic cycle(input logic r, input logic md, input logic [1:0] s,
                       input logic [3:0] v, input logic [31:0] d, input logic ordy);
    int         g;
    logic       load;
    logic [3:0] er;
    rst = r; mode = md; sel = s; in_valid = v; in_data = d; out_ready = ordy;
    #1;
    g    = ref_grant();
    load = (m_valid == 0) || ordy;
    er   = (!r && load && g >= 0) ? 4'(1 << g) : 4'b0;
    check("in_ready", 32'(in_ready), 32'(er));
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 3;
    end else if (load && g >= 0) begin
      m_valid = 1; m_data = (d >> (8 * g)) & 32'hFF; m_ch = g;
      if (md) m_ptr = g;
    end else if (ordy) begin
      m_valid = 0;
    end
    @(negedge clk);
    check("o_valid", 32'(o_valid), m_valid);
    check("o_data",  32'(o_data),  m_data);
    check("o_ch",    32'(o_ch),    m_ch);
  endtask

  initial begin
    logic [7:0] held;
    rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b1;
    rst3 = 1'b1; sel3 = 2'd3; valid3 = 3'b111; data3 = 24'h33_22_11;
    m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 3;
    @(negedge clk);

    repeat (2) cycle(1'b1, 1'b0, 2'd0, 4'hF, 32'hDEAD_BEEF, 1'b1);

    cycle(1'b0, 1'b0, 2'd2, 4'hF, 32'h44A5_2211, 1'b1);
    check("fixed_data", 32'(o_data), 32'hA5);
    check("fixed_ch",   32'(o_ch),   32'd2);

    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 2'd0, 4'hF, $urandom, 1'b1);
      check("rr_seq", 32'(o_ch), i % 4);
    end

    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 2'd0, 4'b1010, $urandom, 1'b1);
      check("rr_alt", 32'(o_ch), (i % 2) ? 3 : 1);
    end

    held = o_data;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 2'd0, 4'hF, $urandom, 1'b0);
      check("bp_hold", 32'(o_data), 32'(held));
    end
    cycle(1'b0, 1'b1, 2'd0, 4'hF, 32'h0000_0077, 1'b1);
    check("bp_release_ch",   32'(o_ch),   32'd0);
    check("bp_release_data", 32'(o_data), 32'h77);

    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 49) == 0), 1'($urandom), 2'($urandom),
            4'($urandom), $urandom, ($urandom_range(0, 3) != 0));

    @(posedge clk); #1;
    rst3 = 1'b0;
    #1;
    check("n3_sel3_ready", 32'(ready3), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("n3_sel3_valid", 32'(ov3), 32'd0);
    sel3 = 2'd1;
    @(posedge clk); #1;
    check("n3_sel1_valid", 32'(ov3), 32'd1);
    check("n3_sel1_data",  32'(od3), 32'h22);
    check("n3_sel1_ch",    32'(oc3), 32'd1);
    rst3 = 1'b1;
    @(posedge clk); #1;
    check("n3_rst_valid",  32'(ov3), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
